// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment patterns for
// the sixteen hex glyphs, capture FSM states and digit slot indices.
package seven_seg_pkg;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic UPPER = 1'b1;
    localparam logic LOWER = 1'b0;

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Maps a seven-segment pattern back to its hex nibble; patterns that are not
// one of the sixteen glyphs (including blank) decode to 0 with valid low.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Rebuilds the two-digit word from a multiplexed seven-segment bus: each slot
// is latched once the bus has been stable for SETTLE cycles after a phase edge.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2048,
    parameter int TBITS   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segment,
    input  logic        digit_select,
    output logic [13:0] both7seg,
    output logic [7:0]  hex,
    output logic [1:0]  hex_valid,
    output logic        frame_valid,
    output logic        stalled
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0]    SETTLE_C  = CW'(SETTLE);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [TBITS-1:0] TO_C      = TBITS'(TIMEOUT);
    localparam logic [TBITS-1:0] TO_M1     = TBITS'(TIMEOUT - 1);
    localparam logic [TBITS-1:0] TCNT_ONE  = TBITS'(1);

    state_t            state_q, state_d;
    logic              ds_q;
    logic [6:0]        seg_q, seg_d;
    logic              slot_q, slot_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TBITS-1:0]  tcnt_q;
    logic              upper_seen;
    logic              edge_det;
    logic              capture;
    logic              dec_valid;
    logic [3:0]        dec_nibble;

    assign edge_det = (digit_select != ds_q);

    // seg_d is the pattern being latched this cycle, so the decode is ready in
    // the capture cycle even when SETTLE=1 captures straight out of IDLE.
    seg7_decode u_decode (
        .pattern (seg_d),
        .valid   (dec_valid),
        .nibble  (dec_nibble)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The phase-edge cycle counts as the first stable cycle of the new slot.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (edge_det) begin
                    state_d = S_SETTLE;
                    seg_d   = segment;
                    slot_d  = digit_select;
                    cnt_d   = CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (edge_det) begin
                    seg_d  = segment;
                    slot_d = digit_select;
                    cnt_d  = CNT_ONE;
                end else if (segment != seg_q) begin
                    seg_d = segment;
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_d == S_SETTLE) && (cnt_d >= SETTLE_C)) begin
            capture = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_q        <= 1'b0;
            seg_q       <= '0;
            slot_q      <= LOWER;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            upper_seen  <= 1'b0;
            both7seg    <= '0;
            hex         <= '0;
            hex_valid   <= 2'b00;
            frame_valid <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            ds_q        <= digit_select;
            seg_q       <= seg_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            frame_valid <= 1'b0;
            // A capture always beats the timeout threshold in the same cycle.
            if (capture) begin
                tcnt_q  <= '0;
                stalled <= 1'b0;
                if (slot_d == UPPER) begin
                    both7seg[13:7] <= seg_d;
                    hex[7:4]       <= dec_nibble;
                    hex_valid[1]   <= dec_valid;
                    upper_seen     <= 1'b1;
                end else begin
                    both7seg[6:0] <= seg_d;
                    hex[3:0]      <= dec_nibble;
                    hex_valid[0]  <= dec_valid;
                    if (upper_seen) begin
                        frame_valid <= 1'b1;
                        upper_seen  <= 1'b0;
                    end
                end
            end else if (tcnt_q >= TO_M1) begin
                tcnt_q     <= TO_C;
                stalled    <= 1'b1;
                hex_valid  <= 2'b00;
                upper_seen <= 1'b0;
            end else begin
                tcnt_q <= tcnt_q + TCNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: expected output snapshots are queued
// against the cycle they must appear in and checked by an independent monitor.
module tb_seven_seg_capture;

    logic        clk;
    logic        rst;
    logic [6:0]  segment;
    logic        digit_select;
    logic [13:0] both7seg;
    logic [7:0]  hex;
    logic [1:0]  hex_valid;
    logic        frame_valid;
    logic        stalled;

    seven_seg_capture #(.SETTLE(4), .TIMEOUT(2048), .TBITS(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .segment      (segment),
        .digit_select (digit_select),
        .both7seg     (both7seg),
        .hex          (hex),
        .hex_valid    (hex_valid),
        .frame_valid  (frame_valid),
        .stalled      (stalled)
    );

    typedef struct {
        int          cyc;
        string       nm;
        logic [13:0] b;
        logic [7:0]  h;
        logic [1:0]  hv;
        logic        fv;
        logic        st;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_fv = 0;
    int   k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string nm, input logic [13:0] b,
                             input logic [7:0] h, input logic [1:0] hv,
                             input logic fv, input logic st);
        exp_t x;
        x.cyc = c; x.nm = nm; x.b = b; x.h = h; x.hv = hv; x.fv = fv; x.st = st;
        q.push_back(x);
    endtask

    // Monitor: counts frame pulses and checks every snapshot due at this cycle.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) n_fv++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || both7seg !== e.b || hex !== e.h || hex_valid !== e.hv ||
                frame_valid !== e.fv || stalled !== e.st) begin
                n_fail++;
                $display("FAIL %s cyc=%0d due=%0d: got both=%h hex=%h hv=%b fv=%b st=%b, want both=%h hex=%h hv=%b fv=%b st=%b",
                         e.nm, cyc, e.cyc, both7seg, hex, hex_valid, frame_valid, stalled,
                         e.b, e.h, e.hv, e.fv, e.st);
            end
        end
    end

    task automatic drive(input logic d, input logic [6:0] s);
        @(posedge clk);
        #1;
        digit_select = d;
        segment      = s;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        digit_select = 1'b0;
        segment      = 7'h00;
        expect_at(2, "reset_held", 14'h0000, 8'h00, 2'b00, 1'b0, 1'b0);
        hold(3);
        #1 rst = 1'b0;
        expect_at(cyc + 2, "reset_release", 14'h0000, 8'h00, 2'b00, 1'b0, 1'b0);

        // Upper digit 2
        drive(1'b1, 7'h5B); k = cyc;
        expect_at(k + 3, "upper2_pre",  14'h0000, 8'h00, 2'b00, 1'b0, 1'b0);
        expect_at(k + 4, "upper2_cap",  14'h2D80, 8'h20, 2'b10, 1'b0, 1'b0);
        expect_at(k + 9, "upper2_hold", 14'h2D80, 8'h20, 2'b10, 1'b0, 1'b0);
        hold(9);

        // Lower digit 1 completes the frame
        drive(1'b0, 7'h06); k = cyc;
        expect_at(k + 3, "lower1_pre",   14'h2D80, 8'h20, 2'b10, 1'b0, 1'b0);
        expect_at(k + 4, "lower1_frame", 14'h2D86, 8'h21, 2'b11, 1'b1, 1'b0);
        expect_at(k + 5, "lower1_post",  14'h2D86, 8'h21, 2'b11, 1'b0, 1'b0);
        hold(9);

        // Upper 1, then a chattering lower slot that must not latch early
        drive(1'b1, 7'h06); k = cyc;
        expect_at(k + 4, "upper1_cap", 14'h0306, 8'h11, 2'b11, 1'b0, 1'b0);
        hold(7);
        drive(1'b0, 7'h3F); hold(1);
        drive(1'b0, 7'h06); hold(1);
        drive(1'b0, 7'h3F); hold(1);
        drive(1'b0, 7'h06); hold(1);
        drive(1'b0, 7'h3F); k = cyc;
        expect_at(k + 3, "chatter_none",  14'h0306, 8'h11, 2'b11, 1'b0, 1'b0);
        expect_at(k + 4, "lower0_stable", 14'h033F, 8'h10, 2'b11, 1'b1, 1'b0);
        hold(7);

        // Illegal upper pattern
        drive(1'b1, 7'h01); k = cyc;
        expect_at(k + 4, "upper_illegal", 14'h00BF, 8'h00, 2'b01, 1'b0, 1'b0);
        hold(7);

        // Frame, then a silent driver until the stall fires
        drive(1'b0, 7'h7F); k = cyc;
        expect_at(k + 4, "lower8_frame", 14'h00FF, 8'h08, 2'b01, 1'b1, 1'b0);
        expect_at(k + 4 + 2047, "stall_pre", 14'h00FF, 8'h08, 2'b01, 1'b0, 1'b0);
        expect_at(k + 4 + 2048, "stall_set", 14'h00FF, 8'h08, 2'b00, 1'b0, 1'b1);
        hold(2060);

        drive(1'b1, 7'h6F); k = cyc;
        expect_at(k + 3, "stall_hold",  14'h00FF, 8'h08, 2'b00, 1'b0, 1'b1);
        expect_at(k + 4, "stall_clear", 14'h37FF, 8'h98, 2'b10, 1'b0, 1'b0);
        hold(7);
        drive(1'b0, 7'h4F); k = cyc;
        expect_at(k + 4, "lower3_frame", 14'h37CF, 8'h93, 2'b11, 1'b1, 1'b0);
        hold(7);

        // Reset in the middle of a lower slot's settle window
        drive(1'b1, 7'h66); k = cyc;
        expect_at(k + 4, "upper4_cap", 14'h334F, 8'h43, 2'b11, 1'b0, 1'b0);
        hold(7);
        drive(1'b0, 7'h6D); k = cyc;
        hold(2);
        #1 rst = 1'b1;
        hold(1);
        #1 rst = 1'b0;
        expect_at(k + 3, "midsettle_rst", 14'h0000, 8'h00, 2'b00, 1'b0, 1'b0);
        expect_at(k + 6, "rst_no_cap",    14'h0000, 8'h00, 2'b00, 1'b0, 1'b0);
        hold(6);
        drive(1'b1, 7'h7D); k = cyc;
        expect_at(k + 4, "resume_upper6", 14'h3E80, 8'h60, 2'b10, 1'b0, 1'b0);
        hold(7);
        drive(1'b0, 7'h07); k = cyc;
        expect_at(k + 4, "resume_frame",  14'h3E87, 8'h67, 2'b11, 1'b1, 1'b0);
        hold(8);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d left, want 0", q.size());
        end
        n_cmp++;
        if (n_fv != 5) begin
            n_fail++;
            $display("FAIL frame_pulse_count: got %0d, want 5", n_fv);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
